gpio_port: RTL and testbench

- Parametrised GPIO peripheral for cpu_soc.
- Replaces the fixed 8-bit gpio_o/gpio_i/gpio_oe wiring with a register-mapped port of WIDTH pins.
- Adds per-pin input synchronisation, open-drain mode, and rising/falling edge interrupt capture.
- The aggregated interrupt drives the CPU interrupt line.

---
 rtl/gpio_port.sv | 144 ++++++++++++++
 tb/tb_gpio_port.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_port.sv
// gpio_port: register-mapped GPIO with synchronised inputs, open-drain drive and edge interrupts.
// Latency: bus_ack/bus_rdata 1 cycle after bus_request; pin -> DATA_IN SYNC_STAGES, pin -> irq SYNC_STAGES+1.
// Backpressure: none; every request is accepted and acked next cycle, back-to-back requests allowed.
module gpio_port #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bus_request,
    input  logic             bus_write,
    input  logic [2:0]       bus_address,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata,
    output logic             bus_ack,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA_OUT = 3'd0;
    localparam logic [2:0] ADDR_OE       = 3'd1;
    localparam logic [2:0] ADDR_OD       = 3'd2;
    localparam logic [2:0] ADDR_DATA_IN  = 3'd3;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd5;
    localparam logic [2:0] ADDR_PENDING  = 3'd6;

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] oe;
    logic [WIDTH-1:0] open_drain;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] pending;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_lvl;
    logic [WIDTH-1:0] prev_q;

    logic [WIDTH-1:0] wr_data;
    logic             wr_en;
    logic [WIDTH-1:0] set_bits;
    logic [WIDTH-1:0] clr_bits;
    logic [WIDTH-1:0] rd_val;
    logic [31:0]      rd_word;

    // Bits of bus_wdata above WIDTH have no register behind them.
    logic wdata_unused;
    assign wdata_unused = &{1'b0, bus_wdata};

    assign wr_en    = bus_request & bus_write;
    assign wr_data  = bus_wdata[WIDTH-1:0];
    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Writable configuration and output registers (DATA_IN, IRQ_PENDING and addr 7 handled elsewhere)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out   <= RESET_OUT;
            oe         <= '0;
            open_drain <= '0;
            rise_en    <= '0;
            fall_en    <= '0;
        end else if (wr_en) begin
            case (bus_address)
                ADDR_DATA_OUT: data_out   <= wr_data;
                ADDR_OE:       oe         <= wr_data;
                ADDR_OD:       open_drain <= wr_data;
                ADDR_RISE_EN:  rise_en    <= wr_data;
                ADDR_FALL_EN:  fall_en    <= wr_data;
                default:       ;
            endcase
        end
    end

    // Metastability chain on the raw pins, plus one extra sample for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_lvl;
        end
    end

    // Enabled edges set pending; software clears with write-1; a same-cycle set beats the clear
    always_comb begin
        set_bits = ((sync_lvl & ~prev_q) & rise_en) | ((~sync_lvl & prev_q) & fall_en);
        clr_bits = (wr_en && (bus_address == ADDR_PENDING)) ? wr_data : '0;
    end

    // Sticky interrupt pending bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_bits) | set_bits;
        end
    end

    // Read decode, zero-extended to the 32-bit bus
    always_comb begin
        rd_val = '0;
        case (bus_address)
            ADDR_DATA_OUT: rd_val = data_out;
            ADDR_OE:       rd_val = oe;
            ADDR_OD:       rd_val = open_drain;
            ADDR_DATA_IN:  rd_val = sync_lvl;
            ADDR_RISE_EN:  rd_val = rise_en;
            ADDR_FALL_EN:  rd_val = fall_en;
            ADDR_PENDING:  rd_val = pending;
            default:       rd_val = '0;
        endcase
        rd_word = '0;
        rd_word[WIDTH-1:0] = rd_val;
    end

    // Registered single-cycle response; write acks carry zero data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
        end else begin
            bus_ack   <= bus_request;
            bus_rdata <= (bus_request && !bus_write) ? rd_word : '0;
        end
    end

    // Pin drive: open-drain pins only ever pull low, releasing to high-Z when DATA_OUT is 1
    always_comb begin
        gpio_o  = data_out & ~open_drain;
        gpio_oe = oe & (~open_drain | ~data_out);
    end

    assign irq = |pending;

endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: checks three gpio_port configurations (8/2, 1/4, 32/4) against a delay-line model.
// Latency: model advances once per clock; outputs compared 1 time unit after each rising edge.
// Backpressure: not applicable; bus requests are driven freely, one per DUT per cycle at most.
module tb_gpio_port;

    localparam int NDUT = 3;
    localparam logic [31:0] MASK    [NDUT] = '{32'h0000_00FF, 32'h0000_0001, 32'hFFFF_FFFF};
    localparam logic [31:0] RST_OUT [NDUT] = '{32'h0000_00A5, 32'h0000_0001, 32'h1234_5678};
    localparam int          SS      [NDUT] = '{2, 4, 4};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req   [NDUT];
    logic        wr    [NDUT];
    logic [2:0]  addr  [NDUT];
    logic [31:0] wdata [NDUT];
    logic [31:0] gin   [NDUT];
    logic [31:0] rdata [NDUT];
    logic        ack   [NDUT];
    logic        irq_w [NDUT];

    logic [7:0]  go8,  oe8;
    logic [0:0]  go1,  oe1;
    logic [31:0] go32, oe32;
    logic [31:0] go [NDUT];
    logic [31:0] goe [NDUT];
    assign go[0]  = {24'd0, go8};
    assign goe[0] = {24'd0, oe8};
    assign go[1]  = {31'd0, go1};
    assign goe[1] = {31'd0, oe1};
    assign go[2]  = go32;
    assign goe[2] = oe32;

    gpio_port #(.WIDTH(8), .SYNC_STAGES(2), .RESET_OUT(8'hA5)) dut8 (
        .clk(clk), .reset(reset),
        .bus_request(req[0]), .bus_write(wr[0]), .bus_address(addr[0]), .bus_wdata(wdata[0]),
        .bus_rdata(rdata[0]), .bus_ack(ack[0]),
        .gpio_i(gin[0][7:0]), .gpio_o(go8), .gpio_oe(oe8), .irq(irq_w[0])
    );

    gpio_port #(.WIDTH(1), .SYNC_STAGES(4), .RESET_OUT(1'b1)) dut1 (
        .clk(clk), .reset(reset),
        .bus_request(req[1]), .bus_write(wr[1]), .bus_address(addr[1]), .bus_wdata(wdata[1]),
        .bus_rdata(rdata[1]), .bus_ack(ack[1]),
        .gpio_i(gin[1][0:0]), .gpio_o(go1), .gpio_oe(oe1), .irq(irq_w[1])
    );

    gpio_port #(.WIDTH(32), .SYNC_STAGES(4), .RESET_OUT(32'h1234_5678)) dut32 (
        .clk(clk), .reset(reset),
        .bus_request(req[2]), .bus_write(wr[2]), .bus_address(addr[2]), .bus_wdata(wdata[2]),
        .bus_rdata(rdata[2]), .bus_ack(ack[2]),
        .gpio_i(gin[2]), .gpio_o(go32), .gpio_oe(oe32), .irq(irq_w[2])
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain register values plus a history of pin samples (newest first).
    logic [31:0] m_dout [NDUT];
    logic [31:0] m_oe   [NDUT];
    logic [31:0] m_od   [NDUT];
    logic [31:0] m_ren  [NDUT];
    logic [31:0] m_fen  [NDUT];
    logic [31:0] m_pend [NDUT];
    logic [31:0] m_hist [NDUT][6];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            m_dout[d] = RST_OUT[d];
            m_oe[d]   = '0;
            m_od[d]   = '0;
            m_ren[d]  = '0;
            m_fen[d]  = '0;
            m_pend[d] = '0;
            for (int j = 0; j < 6; j++) m_hist[d][j] = '0;
        end
    endtask

    // Level seen by software = pin value sampled SYNC_STAGES edges before now.
    function automatic logic [31:0] model_read(int d, logic [2:0] a);
        case (a)
            3'd0: return m_dout[d];
            3'd1: return m_oe[d];
            3'd2: return m_od[d];
            3'd3: return m_hist[d][SS[d]-1];
            3'd4: return m_ren[d];
            3'd5: return m_fen[d];
            3'd6: return m_pend[d];
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_outputs(int d);
        logic [31:0] e_o, e_oe;
        e_o  = m_dout[d] & ~m_od[d] & MASK[d];
        e_oe = m_oe[d] & (~m_od[d] | ~m_dout[d]) & MASK[d];
        check($sformatf("d%0d_gpio_o", d), go[d], e_o);
        check($sformatf("d%0d_gpio_oe", d), goe[d], e_oe);
        check($sformatf("d%0d_irq", d), {31'd0, irq_w[d]}, {31'd0, |m_pend[d]});
    endtask

    // One clock: predict from pre-edge model state and inputs, advance model, compare.
    task automatic tick();
        logic        e_ack [NDUT];
        logic [31:0] e_rd  [NDUT];
        logic [31:0] setb  [NDUT];
        logic        we    [NDUT];
        logic [2:0]  a     [NDUT];
        logic [31:0] wd    [NDUT];
        logic [31:0] pin   [NDUT];
        logic [31:0] s, p, clr;
        for (int d = 0; d < NDUT; d++) begin
            e_ack[d] = req[d];
            e_rd[d]  = (req[d] && !wr[d]) ? (model_read(d, addr[d]) & MASK[d]) : 32'h0;
            s        = m_hist[d][SS[d]-1];
            p        = m_hist[d][SS[d]];
            setb[d]  = ((s & ~p & m_ren[d]) | (~s & p & m_fen[d])) & MASK[d];
            we[d]    = req[d] & wr[d];
            a[d]     = addr[d];
            wd[d]    = wdata[d] & MASK[d];
            pin[d]   = gin[d] & MASK[d];
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            for (int j = 5; j > 0; j--) m_hist[d][j] = m_hist[d][j-1];
            m_hist[d][0] = pin[d];
            clr = '0;
            if (we[d]) begin
                case (a[d])
                    3'd0: m_dout[d] = wd[d];
                    3'd1: m_oe[d]   = wd[d];
                    3'd2: m_od[d]   = wd[d];
                    3'd4: m_ren[d]  = wd[d];
                    3'd5: m_fen[d]  = wd[d];
                    3'd6: clr       = wd[d];
                    default: ;
                endcase
            end
            m_pend[d] = ((m_pend[d] & ~clr) | setb[d]) & MASK[d];
            check($sformatf("d%0d_ack", d), {31'd0, ack[d]}, {31'd0, e_ack[d]});
            if (e_ack[d]) check($sformatf("d%0d_rdata", d), rdata[d], e_rd[d]);
            check_outputs(d);
        end
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic bus_op(int d, logic w, logic [2:0] a, logic [31:0] wd);
        req[d]   = 1'b1;
        wr[d]    = w;
        addr[d]  = a;
        wdata[d] = wd;
        tick();
        req[d]   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("d%0d_rst_ack", d), {31'd0, ack[d]}, 32'h0);
            check_outputs(d);
            req[d] = 1'b0;
        end
        reset = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [7:0]  exp_o;
        logic [7:0]  exp_oe;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1'b0, 3'd0, 32'h0000_0000, 32'h0000_00A5, 8'hA5, 8'h00};
        tbl[1]  = '{1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0000_0000, 8'hA5, 8'hFF};
        tbl[2]  = '{1'b1, 3'd0, 32'h0000_000F, 32'h0000_0000, 8'h0F, 8'hFF};
        tbl[3]  = '{1'b1, 3'd2, 32'h0000_00F0, 32'h0000_0000, 8'h0F, 8'hFF};
        tbl[4]  = '{1'b1, 3'd0, 32'h0000_00FF, 32'h0000_0000, 8'h0F, 8'h0F};
        tbl[5]  = '{1'b0, 3'd2, 32'h0000_0000, 32'h0000_00F0, 8'h0F, 8'h0F};
        tbl[6]  = '{1'b0, 3'd1, 32'h0000_0000, 32'h0000_00FF, 8'h0F, 8'h0F};
        tbl[7]  = '{1'b1, 3'd3, 32'h0000_00FF, 32'h0000_0000, 8'h0F, 8'h0F};
        tbl[8]  = '{1'b0, 3'd3, 32'h0000_0000, 32'h0000_0000, 8'h0F, 8'h0F};
        tbl[9]  = '{1'b1, 3'd7, 32'h0000_0055, 32'h0000_0000, 8'h0F, 8'h0F};
        tbl[10] = '{1'b0, 3'd7, 32'h0000_0000, 32'h0000_0000, 8'h0F, 8'h0F};
        tbl[11] = '{1'b0, 3'd0, 32'h0000_0000, 32'h0000_00FF, 8'h0F, 8'h0F};

        for (int d = 0; d < NDUT; d++) begin
            req[d] = 1'b0; wr[d] = 1'b0; addr[d] = 3'd0; wdata[d] = '0; gin[d] = '0;
        end
        do_reset();
        check("rst_gpio_o_A5", {24'd0, go8}, 32'h0000_00A5);

        // Register map and push-pull / open-drain drive, 8-bit port
        for (int i = 0; i < 12; i++) begin
            bus_op(0, tbl[i].w, tbl[i].a, tbl[i].wd);
            check($sformatf("tbl%0d_rdata", i), rdata[0], tbl[i].exp_rd);
            check($sformatf("tbl%0d_gpio_o", i), {24'd0, go8}, {24'd0, tbl[i].exp_o});
            check($sformatf("tbl%0d_gpio_oe", i), {24'd0, oe8}, {24'd0, tbl[i].exp_oe});
        end

        // Rise/fall interrupt capture and write-1-to-clear
        do_reset();
        gin[0] = 32'h02;
        idle(5);
        bus_op(0, 1'b1, 3'd4, 32'h01);
        bus_op(0, 1'b1, 3'd5, 32'h02);
        gin[0] = 32'h03;
        idle(2);
        check("irq_before_cycle3", {31'd0, irq_w[0]}, 32'h0);
        idle(1);
        check("irq_at_cycle3", {31'd0, irq_w[0]}, 32'h1);
        bus_op(0, 1'b0, 3'd6, 32'h0);
        check("pend_rise0", rdata[0], 32'h01);
        gin[0] = 32'h01;
        idle(3);
        bus_op(0, 1'b0, 3'd6, 32'h0);
        check("pend_fall1", rdata[0], 32'h03);
        gin[0] = 32'h05;
        idle(4);
        bus_op(0, 1'b0, 3'd6, 32'h0);
        check("pend_disabled_pin2", rdata[0], 32'h03);
        bus_op(0, 1'b1, 3'd6, 32'h01);
        bus_op(0, 1'b0, 3'd6, 32'h0);
        check("pend_after_clr0", rdata[0], 32'h02);
        check("irq_after_clr0", {31'd0, irq_w[0]}, 32'h1);
        bus_op(0, 1'b1, 3'd6, 32'h02);
        check("irq_after_clr1", {31'd0, irq_w[0]}, 32'h0);

        // Set wins over a clear landing on the same edge
        gin[0] = 32'h04;
        idle(4);
        gin[0] = 32'h05;
        idle(2);
        bus_op(0, 1'b1, 3'd6, 32'h01);
        check("setwins_irq", {31'd0, irq_w[0]}, 32'h1);
        bus_op(0, 1'b0, 3'd6, 32'h0);
        check("setwins_pend", rdata[0], 32'h01);
        bus_op(0, 1'b1, 3'd6, 32'h01);
        check("clr_alone_irq", {31'd0, irq_w[0]}, 32'h0);

        // Synchroniser latency on pin 3, then a sub-cycle pulse that no edge samples
        gin[0] = 32'h0D;
        bus_op(0, 1'b0, 3'd3, 32'h0);
        check("sync_cyc0", rdata[0], 32'h05);
        bus_op(0, 1'b0, 3'd3, 32'h0);
        check("sync_cyc1", rdata[0], 32'h05);
        bus_op(0, 1'b0, 3'd3, 32'h0);
        check("sync_cyc2", rdata[0], 32'h0D);
        gin[0] = 32'h1D;
        #3;
        gin[0] = 32'h0D;
        idle(4);
        bus_op(0, 1'b0, 3'd3, 32'h0);
        check("narrow_pulse", rdata[0], 32'h0D);

        // WIDTH=1 and WIDTH=32 corners, SYNC_STAGES=4
        bus_op(1, 1'b1, 3'd1, 32'hFFFF_FFFF);
        bus_op(1, 1'b0, 3'd1, 32'h0);
        check("w1_oe_read", rdata[1], 32'h1);
        bus_op(1, 1'b0, 3'd7, 32'h0);
        check("w1_addr7", rdata[1], 32'h0);
        bus_op(1, 1'b1, 3'd4, 32'h1);
        gin[1] = 32'h1;
        idle(4);
        check("w1_irq_cycle4", {31'd0, irq_w[1]}, 32'h0);
        idle(1);
        check("w1_irq_cycle5", {31'd0, irq_w[1]}, 32'h1);
        bus_op(2, 1'b1, 3'd1, 32'hFFFF_FFFF);
        bus_op(2, 1'b0, 3'd1, 32'h0);
        check("w32_oe_read", rdata[2], 32'hFFFF_FFFF);
        bus_op(2, 1'b1, 3'd4, 32'h8000_0000);
        gin[2] = 32'h8000_0000;
        idle(4);
        check("w32_irq_cycle4", {31'd0, irq_w[2]}, 32'h0);
        idle(1);
        check("w32_irq_cycle5", {31'd0, irq_w[2]}, 32'h1);
        bus_op(2, 1'b0, 3'd7, 32'h0);
        check("w32_addr7", rdata[2], 32'h0);

        // Randomised traffic and pin activity against the model
        for (int c = 0; c < 2000; c++) begin
            for (int d = 0; d < NDUT; d++) begin
                req[d]   = ($urandom_range(0, 1) == 1);
                wr[d]    = ($urandom_range(0, 1) == 1);
                addr[d]  = 3'($urandom_range(0, 7));
                wdata[d] = $urandom;
                if ($urandom_range(0, 2) == 0) gin[d] = gin[d] ^ $urandom;
            end
            tick();
        end
        for (int d = 0; d < NDUT; d++) req[d] = 1'b0;
        idle(2);

        // Asynchronous reset while reads are in flight: no ack, everything back to reset values
        for (int d = 0; d < NDUT; d++) begin
            req[d] = 1'b1; wr[d] = 1'b0; addr[d] = 3'd0;
        end
        #3;
        do_reset();
        for (int d = 0; d < NDUT; d++) begin
            for (int a = 0; a < 8; a++) begin
                bus_op(d, 1'b0, 3'(a), 32'h0);
                if (a == 0) check($sformatf("d%0d_postrst_a0", d), rdata[d], RST_OUT[d]);
                else if (a != 3) check($sformatf("d%0d_postrst_a%0d", d, a), rdata[d], 32'h0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
